// File: rtl/bitpack_pkg.sv
// ============================================================================
//  Module      : bitpack_pkg
//  Description : Shared types and helpers for the bit-stream packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitpack_pkg;

    // Packer control states: normal packing, or emitting the tail word.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Widest fragment the mask helper can describe; callers cast the
    // result down to their own fragment width.
    localparam int c_MASK_MAX_W = 1024;

    // Mask with the low 'len' bits set.
    function automatic logic [c_MASK_MAX_W-1:0] len_mask(input int unsigned len);
        return ~({c_MASK_MAX_W{1'b1}} << len);
    endfunction

    // Round 'sum' up to the next multiple of 'align' (a power of two);
    // already-aligned values are returned unchanged.
    function automatic logic [31:0] align_up(input logic [31:0] sum,
                                             input logic [31:0] align);
        return (sum + align - 32'd1) & ~(align - 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_packer_stream_if.sv
// ============================================================================
//  Module      : bit_packer_stream_if
//  Description : Fragment input stream, packed word output stream and
//                status signals of the bit-stream packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bit_packer_stream_if #(
    parameter int OUT_W = 256,
    parameter int IN_W  = 256,
    parameter int LEN_W = $clog2(IN_W) + 1,
    parameter int CNT_W = 32
);
    localparam int FILL_W = $clog2(OUT_W) + 1;

    logic [IN_W-1:0]   in_data;
    logic [LEN_W-1:0]  in_len;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  out_data;
    logic [FILL_W-1:0] out_bits;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [FILL_W-1:0] fill_level;
    logic [CNT_W-1:0]  word_count;

    // Environment side: produces fragments, consumes words.
    modport master (
        output in_data, in_len, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_bits, out_last, out_valid,
               fill_level, word_count
    );

    // Packer side.
    modport slave (
        input  in_data, in_len, in_last, in_valid, out_ready,
        output in_ready, out_data, out_bits, out_last, out_valid,
               fill_level, word_count
    );

endinterface

`default_nettype wire

// File: rtl/bit_packer_shift.sv
// ============================================================================
//  Module      : bit_packer_shift
//  Description : Combinational datapath of the packer: clamps and masks the
//                incoming fragment, shifts it above the held bits and
//                computes the (optionally aligned) new bit total.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_packer_shift
    import bitpack_pkg::*;
#(
    parameter int OUT_W = 256,
    parameter int IN_W  = 256,
    parameter int ALIGN = 8,
    parameter int LEN_W = $clog2(IN_W) + 1
) (
    input  wire logic [OUT_W-1:0]            acc_i,
    input  wire logic [$clog2(OUT_W):0]      fill_i,
    input  wire logic [IN_W-1:0]             data_i,
    input  wire logic [LEN_W-1:0]            len_i,
    input  wire logic                        last_i,
    output logic      [2*OUT_W-1:0]          working_o,
    output logic      [$clog2(OUT_W)+1:0]    sum_o
);
    localparam int WORK_W = 2 * OUT_W;
    localparam int SUM_W  = $clog2(OUT_W) + 2;

    logic [LEN_W-1:0] w_len_clamped;
    logic [IN_W-1:0]  w_mask;
    logic [IN_W-1:0]  w_data_m;
    logic [SUM_W-1:0] w_raw_sum;

    // Clamp over-long lengths, drop bits beyond the length, then append the
    // fragment above the held bits. Pad bits come out zero because every
    // bit above the raw sum is already zero in the working value.
    always_comb begin
        w_len_clamped = (len_i > LEN_W'(IN_W)) ? LEN_W'(IN_W) : len_i;
        w_mask        = IN_W'(len_mask(32'(w_len_clamped)));
        w_data_m      = data_i & w_mask;
        working_o     = {{OUT_W{1'b0}}, acc_i} | (WORK_W'(w_data_m) << fill_i);
        w_raw_sum     = SUM_W'(fill_i) + SUM_W'(w_len_clamped);
        sum_o         = last_i ? SUM_W'(align_up(32'(w_raw_sum), 32'(ALIGN)))
                               : w_raw_sum;
    end

endmodule

`default_nettype wire

// File: rtl/bit_packer_stream.sv
// ============================================================================
//  Module      : bit_packer_stream
//  Description : Packs LSB-first variable-length code fragments into OUT_W-bit
//                words with valid/ready on both sides; on the last fragment
//                pads to ALIGN bits and flushes the partial tail word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_packer_stream
    import bitpack_pkg::*;
#(
    parameter int OUT_W = 256,
    parameter int IN_W  = 256,
    parameter int ALIGN = 8,
    parameter int LEN_W = $clog2(IN_W) + 1,
    parameter int CNT_W = 32
) (
    input  wire                clk,
    input  wire                reset_n,
    bit_packer_stream_if.slave bus
);
    localparam int FILL_W = $clog2(OUT_W) + 1;
    localparam int SUM_W  = $clog2(OUT_W) + 2;
    localparam int WORK_W = 2 * OUT_W;

    state_e            state_q;
    logic [OUT_W-1:0]  acc_q;
    logic [FILL_W-1:0] fill_q;
    logic [OUT_W-1:0]  out_data_q;
    logic [FILL_W-1:0] out_bits_q;
    logic              out_last_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  word_count_q;

    logic [WORK_W-1:0] w_working;
    logic [SUM_W-1:0]  w_sum;
    logic              w_slot_free;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_full;
    logic              w_exact;

    bit_packer_shift #(
        .OUT_W (OUT_W),
        .IN_W  (IN_W),
        .ALIGN (ALIGN),
        .LEN_W (LEN_W)
    ) u_shift (
        .acc_i     (acc_q),
        .fill_i    (fill_q),
        .data_i    (bus.in_data),
        .len_i     (bus.in_len),
        .last_i    (bus.in_last),
        .working_o (w_working),
        .sum_o     (w_sum)
    );

    // A word leaving this cycle frees the output register for a new one.
    always_comb begin
        w_slot_free = !out_valid_q || bus.out_ready;
        w_in_ready  = (state_q == RUN) && w_slot_free;
        w_accept    = bus.in_valid && w_in_ready;
        w_full      = (w_sum >= SUM_W'(OUT_W));
        w_exact     = (w_sum == SUM_W'(OUT_W));
    end

    // Control FSM, accumulator, output register and word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            out_data_q   <= '0;
            out_bits_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            word_count_q <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                word_count_q <= word_count_q + CNT_W'(1);
            end
            case (state_q)
                RUN: begin
                    if (w_accept && w_full) begin
                        out_data_q  <= w_working[OUT_W-1:0];
                        out_bits_q  <= FILL_W'(OUT_W);
                        out_valid_q <= 1'b1;
                        // A word that exactly ends the stream is its own tail.
                        out_last_q  <= bus.in_last && w_exact;
                        acc_q       <= w_working[WORK_W-1:OUT_W];
                        fill_q      <= FILL_W'(w_sum - SUM_W'(OUT_W));
                        if (bus.in_last && !w_exact) begin
                            state_q <= FLUSH;
                        end
                    end else begin
                        if (w_accept) begin
                            acc_q  <= w_working[OUT_W-1:0];
                            fill_q <= FILL_W'(w_sum);
                            if (bus.in_last) begin
                                state_q <= FLUSH;
                            end
                        end
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // Tail word waits for the output register; an empty
                    // stream still produces a zero-bit last word.
                    if (w_slot_free) begin
                        out_data_q  <= acc_q;
                        out_bits_q  <= fill_q;
                        out_last_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        acc_q       <= '0;
                        fill_q      <= '0;
                        state_q     <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_data   = out_data_q;
    assign bus.out_bits   = out_bits_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.fill_level = fill_q;
    assign bus.word_count = word_count_q;

endmodule

`default_nettype wire
